mac_accum: RTL and testbench

//  Downstream consumer of the input activation controller: takes its byte-serial activation

---
 rtl/mac_accum_pkg.sv | 21 ++
 rtl/mac_accum_sat_adder.sv | 29 ++
 rtl/mac_accum.sv | 215 +++++++++++++++++++++
 tb/tb_mac_accum.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accum_pkg.sv
// Shared widths, FSM encodings and the saturating-add overflow helper for the MAC accumulator.
package mac_accum_pkg;

    localparam int ACT_W = 8;
    localparam int WGT_W = 8;
    localparam int ACC_W = 32;
    localparam int LEN_W = 16;

    typedef logic [1:0] mac_state_e;

    localparam mac_state_e ST_IDLE  = 2'd0;
    localparam mac_state_e ST_ACCUM = 2'd1;
    localparam mac_state_e ST_DRAIN = 2'd2;
    localparam mac_state_e ST_DONE  = 2'd3;

    // Two's-complement add overflowed when both operands share a sign the sum does not.
    function automatic logic sat_add_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/mac_accum_sat_adder.sv
// Signed W-bit adder that clamps to the representable range and flags the clamp.
module sat_adder
    import mac_accum_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic [W-1:0] raw_s;

    assign raw_s = a + b;

    // Clamp toward the operands' common sign when the wrapped sum flips sign.
    always_comb begin
        ovf = sat_add_ovf(a[W-1], b[W-1], raw_s[W-1]);
        if (!ovf) begin
            sum = raw_s;
        end else if (a[W-1]) begin
            sum = {1'b1, {(W-1){1'b0}}};
        end else begin
            sum = {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Byte-serial activation x weight dot product with saturating accumulate, bias, optional ReLU
// and a valid/ready result port.
module mac_accum
    import mac_accum_pkg::*;
#(
    parameter int ACT_WIDTH = ACT_W,
    parameter int WGT_WIDTH = WGT_W,
    parameter int ACC_WIDTH = ACC_W,
    parameter int LEN_WIDTH = LEN_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        acc_len,
    input  logic signed [ACC_WIDTH-1:0] bias,
    input  logic                        relu_en,
    input  logic [ACT_WIDTH-1:0]        in_act_data,
    input  logic                        in_act_valid,
    input  logic [WGT_WIDTH-1:0]        wgt_data,
    output logic                        busy,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        ovf
);

    localparam int PROD_W = ACT_WIDTH + WGT_WIDTH + 1;

    mac_state_e                  state_r;
    mac_state_e                  state_nxt_s;
    logic                        busy_r;
    logic [LEN_WIDTH-1:0]        len_r;
    logic [LEN_WIDTH-1:0]        cnt_r;
    logic signed [ACC_WIDTH-1:0] bias_r;
    logic                        relu_r;
    logic signed [PROD_W-1:0]    prod_r;
    logic                        prod_vld_r;
    logic                        drain_wait_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] result_r;
    logic                        result_valid_r;
    logic                        ovf_r;

    logic signed [PROD_W-1:0]    act_ext_s;
    logic signed [PROD_W-1:0]    wgt_ext_s;
    logic signed [PROD_W-1:0]    prod_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] acc_sum_s;
    logic                        acc_ovf_s;
    logic signed [ACC_WIDTH-1:0] bias_sum_s;
    logic                        bias_ovf_s;
    logic signed [ACC_WIDTH-1:0] result_nxt_s;
    logic                        beat_s;
    logic                        last_beat_s;
    logic                        drain_fire_s;

    // Activation is zero-extended, weight sign-extended, so the full product fits PROD_W bits.
    assign act_ext_s    = {{(WGT_WIDTH+1){1'b0}}, in_act_data};
    assign wgt_ext_s    = {{(ACT_WIDTH+1){wgt_data[WGT_WIDTH-1]}}, wgt_data};
    assign prod_s       = act_ext_s * wgt_ext_s;
    assign prod_ext_s   = {{(ACC_WIDTH-PROD_W){prod_r[PROD_W-1]}}, prod_r};

    assign beat_s       = (state_r == ST_ACCUM) && in_act_valid;
    assign last_beat_s  = beat_s && ((cnt_r + LEN_WIDTH'(1)) == len_r);
    // A zero-length job waits one bubble so its latency matches a job whose last beat hit START's edge.
    assign drain_fire_s = (state_r == ST_DRAIN) && !prod_vld_r && !drain_wait_r;

    sat_adder #(.W(ACC_WIDTH)) u_acc_add (
        .a   (acc_r),
        .b   (prod_ext_s),
        .sum (acc_sum_s),
        .ovf (acc_ovf_s)
    );

    sat_adder #(.W(ACC_WIDTH)) u_bias_add (
        .a   (acc_r),
        .b   (bias_r),
        .sum (bias_sum_s),
        .ovf (bias_ovf_s)
    );

    // ReLU acts on the already-saturated biased sum.
    always_comb begin
        result_nxt_s = bias_sum_s;
        if (relu_r && bias_sum_s[ACC_WIDTH-1]) begin
            result_nxt_s = {ACC_WIDTH{1'b0}};
        end else begin
            result_nxt_s = bias_sum_s;
        end
    end

    // Next-state decode; clear overrides every transition including a coincident start.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (acc_len != {LEN_WIDTH{1'b0}}) begin
                            state_nxt_s = ST_ACCUM;
                        end else begin
                            state_nxt_s = ST_DRAIN;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (last_beat_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_DRAIN: begin
                    if (drain_fire_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, two-stage multiply/accumulate pipe, result register and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            len_r          <= {LEN_WIDTH{1'b0}};
            cnt_r          <= {LEN_WIDTH{1'b0}};
            bias_r         <= {ACC_WIDTH{1'b0}};
            relu_r         <= 1'b0;
            prod_r         <= {PROD_W{1'b0}};
            prod_vld_r     <= 1'b0;
            drain_wait_r   <= 1'b0;
            acc_r          <= {ACC_WIDTH{1'b0}};
            result_r       <= {ACC_WIDTH{1'b0}};
            result_valid_r <= 1'b0;
            ovf_r          <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (clear) begin
                prod_vld_r     <= 1'b0;
                drain_wait_r   <= 1'b0;
                result_valid_r <= 1'b0;
                ovf_r          <= 1'b0;
            end else begin
                prod_vld_r   <= beat_s;
                drain_wait_r <= 1'b0;
                if (beat_s) begin
                    prod_r <= prod_s;
                    cnt_r  <= cnt_r + LEN_WIDTH'(1);
                end
                if (prod_vld_r) begin
                    acc_r <= acc_sum_s;
                    if (acc_ovf_s) begin
                        ovf_r <= 1'b1;
                    end
                end
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            len_r        <= acc_len;
                            bias_r       <= bias;
                            relu_r       <= relu_en;
                            acc_r        <= {ACC_WIDTH{1'b0}};
                            cnt_r        <= {LEN_WIDTH{1'b0}};
                            ovf_r        <= 1'b0;
                            drain_wait_r <= (acc_len == {LEN_WIDTH{1'b0}});
                        end
                    end
                    ST_ACCUM: begin
                    end
                    ST_DRAIN: begin
                        if (drain_fire_s) begin
                            result_r       <= result_nxt_s;
                            result_valid_r <= 1'b1;
                            if (bias_ovf_s) begin
                                ovf_r <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (result_ready) begin
                            result_valid_r <= 1'b0;
                        end
                    end
                    default: begin
                        result_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy         = busy_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign ovf          = ovf_r;

endmodule

// File: tb/tb_mac_accum.sv
// Scoreboard bench for mac_accum: directed dot products with hand-computed results.
module tb_mac_accum;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [15:0] acc_len;
    logic [31:0] bias;
    logic        relu_en;
    logic [7:0]  in_act_data;
    logic        in_act_valid;
    logic [7:0]  wgt_data;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        ovf;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    mac_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .start        (start),
        .acc_len      (acc_len),
        .bias         (bias),
        .relu_en      (relu_en),
        .in_act_data  (in_act_data),
        .in_act_valid (in_act_valid),
        .wgt_data     (wgt_data),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: every accepted result is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got=%0h want=none", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", result, e.res);
                    chk("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf});
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic [31:0] b, input logic r);
        acc_len = len;
        bias    = b;
        relu_en = r;
        start   = 1'b1;
        cycle();
        start   = 1'b0;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] w);
        in_act_data  = a;
        wgt_data     = w;
        in_act_valid = 1'b1;
        cycle();
        in_act_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || result_valid) && n < 60) begin
            cycle();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout got=busy%0d want=idle", busy);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        start        = 1'b0;
        acc_len      = 16'd0;
        bias         = 32'd0;
        relu_en      = 1'b0;
        in_act_data  = 8'd0;
        in_act_valid = 1'b0;
        wgt_data     = 8'd0;
        result_ready = 1'b1;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // T1: 1+2+3+4 with latency check on the last beat
        push(32'd10, 1'b0);
        do_start(16'd4, 32'd0, 1'b0);
        beat(8'd1, 8'd1);
        beat(8'd2, 8'd1);
        beat(8'd3, 8'd1);
        beat(8'd4, 8'd1);
        @(negedge clk);
        chk("t1_valid_k0", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_k1", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_k2", {31'd0, result_valid}, 32'd1);
        cycle();
        wait_done();

        // T2: 255*-128 twice plus 100, with and without ReLU; extra beat must be ignored
        push(32'd0, 1'b0);
        do_start(16'd2, 32'd100, 1'b1);
        beat(8'd255, 8'h80);
        beat(8'd255, 8'h80);
        wait_done();
        push(32'hFFFF0164, 1'b0);
        do_start(16'd2, 32'd100, 1'b0);
        beat(8'd255, 8'h80);
        beat(8'd255, 8'h80);
        beat(8'd200, 8'd100);
        wait_done();

        // T3: zero-length job, result is the bias two edges after start
        push(32'hFFFFFFF9, 1'b0);
        do_start(16'd0, 32'hFFFFFFF9, 1'b0);
        in_act_valid = 1'b1;
        in_act_data  = 8'd9;
        wgt_data     = 8'd9;
        @(negedge clk);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        chk("t3_valid_s0", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        chk("t3_valid_s1", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        chk("t3_valid_s2", {31'd0, result_valid}, 32'd1);
        in_act_valid = 1'b0;
        cycle();
        wait_done();

        // T4: bias add saturates positive
        push(32'h7FFFFFFF, 1'b1);
        do_start(16'd1, 32'h7FFFFFF0, 1'b0);
        beat(8'd255, 8'd127);
        wait_done();
        chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

        // T5: backpressure hold, start pulses ignored, ovf cleared by the new start
        result_ready = 1'b0;
        push(32'd75, 1'b0);
        do_start(16'd2, 32'd5, 1'b1);
        beat(8'd10, 8'hFD);
        beat(8'd20, 8'd5);
        begin
            int n = 0;
            while (!result_valid && n < 20) begin
                cycle();
                n++;
            end
            if (n >= 20) begin
                checks++;
                errors++;
                $display("FAIL t5_valid_timeout got=0 want=1");
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", {31'd0, result_valid}, 32'd1);
            chk("t5_hold_result", result, 32'd75);
            chk("t5_hold_busy", {31'd0, busy}, 32'd1);
            acc_len = 16'd0;
            start   = (i == 3 || i == 7);
            cycle();
            start   = 1'b0;
        end
        result_ready = 1'b1;
        wait_done();
        cycle();
        cycle();
        chk("t5_no_restart", {31'd0, busy | result_valid}, 32'd0);

        // T6: clear mid-accumulate, clear+start collision, then a fresh job
        do_start(16'd4, 32'd0, 1'b0);
        beat(8'd5, 8'd7);
        beat(8'd6, 8'd8);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("t6_clear_busy", {31'd0, busy}, 32'd0);
        chk("t6_clear_valid", {31'd0, result_valid}, 32'd0);
        chk("t6_clear_result_kept", result, 32'd75);
        clear   = 1'b1;
        acc_len = 16'd2;
        start   = 1'b1;
        cycle();
        clear   = 1'b0;
        start   = 1'b0;
        chk("t6_clear_beats_start", {31'd0, busy}, 32'd0);
        push(32'd12, 1'b0);
        do_start(16'd2, 32'd0, 1'b0);
        beat(8'd3, 8'd2);
        beat(8'd3, 8'd2);
        wait_done();

        // Async reset in the middle of a job
        do_start(16'd3, 32'd0, 1'b0);
        beat(8'd1, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        cycle();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
